param_mux_scan: RTL and testbench

- Parametrised, registered N-channel × W-bit multiplexer.
- Next generation of the team's fixed 16:1 single-bit mux tree.
- Adds a channel-enable mask, a manual/auto-scan mode and a valid/ready output handshake.
- Sits between parallel sensor/data lanes and a single serial consumer (UART/display pipeline), time-multiplexing enabled channels onto one stream tagged with channel index.

---
 rtl/param_mux_scan.sv | 109 ++++++++++
 tb/tb_param_mux_scan.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/param_mux_scan.sv
// Registered N-channel x W-bit mux with enable mask, manual select or round-robin auto-scan,
// and a one-deep valid/ready output stage that reloads on the same edge it is drained.
module param_mux_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SEL_W-1:0]   chan_q, chan_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               err_q, err_d;
    logic               mode_q;

    logic [WIDTH-1:0]   ch_dat [CHANNELS];
    logic               load_slot;
    logic               mode_chg;
    logic               man_ok;
    logic [SEL_W-1:0]   scan_base;
    logic               cand_vld;
    logic [SEL_W-1:0]   cand;
    logic [SEL_W-1:0]   ptr_next;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign ch_dat[k] = din[k*WIDTH +: WIDTH];
    end

    assign load_slot = (state_q == EMPTY) || out_ready;
    assign mode_chg  = (mode != mode_q);
    assign man_ok    = (int'(sel_in) < CHANNELS) && ch_en[sel_in];
    // A mode change restarts the search at channel 0 even if a load happens on that same edge.
    assign scan_base = mode_chg ? '0 : ptr_q;
    assign ptr_next  = SEL_W'((int'(cand) + 1) % CHANNELS);

    always_comb begin
        cand_vld = 1'b0;
        cand     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!cand_vld && ch_en[SEL_W'((int'(scan_base) + i) % CHANNELS)]) begin
                cand_vld = 1'b1;
                cand     = SEL_W'((int'(scan_base) + i) % CHANNELS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ptr_d   = mode_chg ? '0 : ptr_q;
        err_d   = 1'b0;
        if (load_slot) begin
            state_d = EMPTY;
            if (!mode) begin
                if (man_ok) begin
                    data_d  = ch_dat[sel_in];
                    chan_d  = sel_in;
                    state_d = FULL;
                end else begin
                    err_d = 1'b1;
                end
            end else if (cand_vld) begin
                data_d  = ch_dat[cand];
                chan_d  = cand;
                ptr_d   = ptr_next;
                state_d = FULL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            mode_q  <= mode;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = (state_q == FULL);
    assign sel_err   = err_q;

endmodule

// File: tb/tb_param_mux_scan.sv
// Directed bench for param_mux_scan: expected samples are queued by the stimulus,
// and an independent monitor pops and compares them on every output handshake.
module tb_param_mux_scan;

    localparam int W = 8;
    localparam int N = 16;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] din;
    logic [N-1:0]   ch_en;
    logic           mode;
    logic [S-1:0]   sel_in;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_chan;
    logic           out_valid;
    logic           out_ready;
    logic           sel_err;

    param_mux_scan #(.WIDTH(W), .CHANNELS(N), .SEL_W(S)) dut (
        .clk(clk), .rst(rst), .din(din), .ch_en(ch_en), .mode(mode), .sel_in(sel_in),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] dat;
        logic [S-1:0] chan;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic logic [N*W-1:0] pattern_din(input int off);
        logic [N*W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(off + k);
        return v;
    endfunction

    // Channel k carries 8'h10+k while the base pattern is driven.
    task automatic push(input int c);
        exp_t e;
        e.dat  = W'(16 + c);
        e.chan = S'(c);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got chan %0d data %0h, expected no sample", out_chan, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_data", 32'(out_data), 32'(mon_e.dat));
                check("sb_chan", 32'(out_chan), 32'(mon_e.chan));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_chan",  32'(out_chan),  32'd0);
        check("rst_err",   32'(sel_err),   32'd0);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        din       = pattern_din(16);
        ch_en     = 16'hFFFF;
        mode      = 1'b0;
        sel_in    = 4'd5;
        out_ready = 1'b1;

        // Manual select of channel 5, continuous draining.
        for (int i = 0; i < 4; i++) push(5);
        do_reset();
        @(posedge clk); #1;
        check("man_valid_rise", 32'(out_valid), 32'd1);
        check("man_data", 32'(out_data), 32'h15);
        drain("man_drain");

        // Auto-scan over a sparse mask.
        rst = 1'b1; mode = 1'b1; ch_en = 16'h8421; out_ready = 1'b1;
        push(0); push(5); push(10); push(15); push(0); push(5);
        do_reset();
        drain("scan_drain");

        // Backpressure: held sample frozen while din churns.
        rst = 1'b1; ch_en = 16'hFFFF; out_ready = 1'b0;
        push(0); push(1); push(2);
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            din = pattern_din(100 + 7 * i);
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data",  32'(out_data),  32'h10);
            check("bp_chan",  32'(out_chan),  32'd0);
        end
        din = pattern_din(16);
        out_ready = 1'b1;
        drain("bp_drain");

        // Manual select of a disabled channel.
        rst = 1'b1; mode = 1'b0; sel_in = 4'd3; ch_en = 16'hFFF7; out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("err_pulse", 32'(sel_err),   32'd1);
            check("err_valid", 32'(out_valid), 32'd0);
        end
        ch_en = 16'hFFFF;
        push(3); push(3); push(3);
        @(posedge clk); #1;
        check("err_fix_valid", 32'(out_valid), 32'd1);
        check("err_fix_chan",  32'(out_chan),  32'd3);
        check("err_fix_err",   32'(sel_err),   32'd0);
        drain("err_drain");

        // Auto-scan with nothing enabled.
        rst = 1'b1; mode = 1'b1; ch_en = 16'h0000; out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("none_valid", 32'(out_valid), 32'd0);
            check("none_err",   32'(sel_err),   32'd0);
        end

        // Scan up to ptr=7 with channel 6 held, toggle mode, scan restarts at 0.
        ch_en = 16'hFFFF;
        for (int c = 0; c < 6; c++) push(c);
        out_ready = 1'b1;
        drain("mc_pre_drain");
        mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("mc_hold_valid", 32'(out_valid), 32'd1);
            check("mc_hold_chan",  32'(out_chan),  32'd6);
        end
        mode = 1'b1;
        push(6); push(0); push(1);
        out_ready = 1'b1;
        drain("mc_drain");

        // Reset while a sample is stalled; it must be dropped.
        check("rmid_pre_valid", 32'(out_valid), 32'd1);
        push(0); push(1); push(2);
        out_ready = 1'b1;
        do_reset();
        drain("rmid_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
